// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
// Shared FSM encoding for the TPL ADC capture stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// IDLE is all-zero. The busy states are one-hot. DONE uses the remaining all-ones code.
package ad_ip_jesd204_tpl_adc_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] STATE_IDLE    = 3'b000;
    localparam logic [STATE_W-1:0] STATE_ARMED   = 3'b001;
    localparam logic [STATE_W-1:0] STATE_CAPTURE = 3'b010;
    localparam logic [STATE_W-1:0] STATE_DRAIN   = 3'b100;
    localparam logic [STATE_W-1:0] STATE_DONE    = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = STATE_IDLE,
        S_ARMED   = STATE_ARMED,
        S_CAPTURE = STATE_CAPTURE,
        S_DRAIN   = STATE_DRAIN,
        S_DONE    = STATE_DONE
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return (s == S_ARMED) || (s == S_CAPTURE) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_if.sv
// AXI-stream link from the capture stage to the DMA.
// Latency: n/a (wiring only).
// Backpressure: ready driven by the slave; valid, data and last hold while ready is low.
// Signals: valid, ready, data[DATA_WIDTH-1:0], last.
interface ad_ip_jesd204_tpl_adc_capture_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a 1-bit last sideband.
// Latency: a write to an empty FIFO shows up on rd_vld on the next cycle.
// Backpressure: rd_* hold while rd_rdy is low. A write into a full FIFO is accepted only if a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), flush, wr_en/wr_data/wr_last, rd_rdy/rd_vld/rd_data/rd_last, full, empty.
module ad_ip_jesd204_tpl_adc_capture_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  rd_rdy,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Each entry holds {last, data}.
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [DATA_WIDTH:0]   mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  push, pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (ADDR_WIDTH+1)'(DEPTH));
    assign rd_vld  = ~empty;
    assign rd_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign rd_last = mem_q[rd_ptr_q][DATA_WIDTH];
    assign pop     = rd_vld & rd_rdy;
    // When full, the slot being written is the one being popped this cycle.
    // The read is combinational from the old contents, so the write is safe.
    assign push    = wr_en & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {wr_last, wr_data};
                wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
                2'b01:   cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Triggered capture of capture_length+1 ADC beats, streamed to the DMA over AXI-stream with TLAST.
// Latency: the first captured beat appears on m_axis one cycle after it is written to the FIFO.
// Backpressure: m_axis.ready stalls the output. Beats that arrive while the FIFO is full are dropped and set overflow.
// Ports: clk, reset (sync, active-high), arm, abort, trigger, trigger_mode, capture_length, adc_valid, adc_data,
//        m_axis (master), busy, done, overflow, fsm_state.
// ADC_CAPTURE_OVF_COUNT_EN adds a saturating 16-bit ovf_count port that counts dropped beats.
module ad_ip_jesd204_tpl_adc_capture
    import ad_ip_jesd204_tpl_adc_pkg::*;
#(
    parameter int NUM_CHANNELS    = 1,
    parameter int DMA_DATA_WIDTH  = 64,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      trigger,
    input  logic                      trigger_mode,
    input  logic [31:0]               capture_length,
    input  logic [NUM_CHANNELS-1:0]   adc_valid,
    input  logic [DMA_DATA_WIDTH-1:0] adc_data,
    ad_ip_jesd204_tpl_adc_capture_if.master m_axis,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    output logic [15:0]               ovf_count,
`endif
    output logic [STATE_W-1:0]        fsm_state
);
    state_e      state_q, state_d;
    logic        trig_d1_q;
    logic [31:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        trig_rise, beat, fifo_wr, fifo_full, fifo_empty, pop, drop, beat_last;
    logic        adc_valid_unused;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
`endif

    // Only channel 0 qualifies a beat.
    assign adc_valid_unused = ^adc_valid;

    assign trig_rise = trigger & ~trig_d1_q;
    assign beat      = (state_q == S_CAPTURE) & adc_valid[0];
    assign fifo_wr   = beat & ~abort;
    assign pop       = m_axis.valid & m_axis.ready;
    assign drop      = fifo_wr & fifo_full & ~pop;
    // The counter is 32 bits wide and is compared before it increments,
    // so a length of all ones never wraps.
    assign beat_last = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
        ovf_cnt_d = ovf_cnt_q;
        if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
`endif
        if (abort) begin
            state_d = S_IDLE;
            ovf_d   = 1'b0;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
                        ovf_cnt_d = '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (!trigger_mode || trig_rise) begin
                        state_d = S_CAPTURE;
                        len_d   = capture_length;
                    end
                end
                S_CAPTURE: begin
                    if (beat) begin
                        // Dropped beats still count, so the capture window is fixed in ADC beats.
                        cnt_d = cnt_q + 32'd1;
                        if (drop) begin
                            ovf_d = 1'b1;
                        end
                        if (beat_last) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Empty FIFO means no pending output beat, because the output is read straight from storage.
                    if (fifo_empty) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = state_is_busy(state_d);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            trig_d1_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            trig_d1_q <= trigger;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    ad_ip_jesd204_tpl_adc_capture_fifo #(
        .DATA_WIDTH (DMA_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .wr_en   (fifo_wr),
        .wr_data (adc_data),
        .wr_last (beat_last),
        .rd_rdy  (m_axis.ready),
        .rd_vld  (m_axis.valid),
        .rd_data (m_axis.data),
        .rd_last (m_axis.last),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign fsm_state = state_q;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// Testbench for the TPL ADC capture stage.
// Directed captures are driven, and the expected beats are queued when they are issued.
// A forked monitor pops the queue on every AXI-stream handshake.
module tb_ad_ip_jesd204_tpl_adc_capture;
    import ad_ip_jesd204_tpl_adc_pkg::*;

    localparam int DW = 64;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, abort, trigger, trigger_mode;
    logic [31:0]   capture_length;
    logic [0:0]    adc_valid;
    logic [DW-1:0] adc_data;
    logic          busy, done, overflow;
    logic [2:0]    fsm_state;
`ifdef ADC_CAPTURE_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ad_ip_jesd204_tpl_adc_capture_if #(.DATA_WIDTH(DW)) m_axis ();

    ad_ip_jesd204_tpl_adc_capture #(
        .NUM_CHANNELS    (1),
        .DMA_DATA_WIDTH  (DW),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arm            (arm),
        .abort          (abort),
        .trigger        (trigger),
        .trigger_mode   (trigger_mode),
        .capture_length (capture_length),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .m_axis         (m_axis),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
`ifdef ADC_CAPTURE_OVF_COUNT_EN
        .ovf_count      (ovf_count),
`endif
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // The monitor samples on the falling edge, when the handshake for the next rising edge is settled.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && m_axis.valid && m_axis.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%h last=%b expected=none", m_axis.data, m_axis.last);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", m_axis.data, e.data);
                    chk("sb_last", 64'(m_axis.last), 64'(e.last));
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] base;
        fork
            monitor();
        join_none

        reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; trigger_mode = 1'b0;
        capture_length = '0; adc_valid = 1'b0; adc_data = '0; m_axis.ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_state",    64'(fsm_state), 64'(STATE_IDLE));
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_done",     64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_valid",    64'(m_axis.valid), 64'd0);
        chk("rst_last",     64'(m_axis.last), 64'd0);
        chk("rst_data",     m_axis.data, 64'd0);
`ifdef ADC_CAPTURE_OVF_COUNT_EN
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif

        // Immediate start, length 7, continuous beats, ready held high.
        base = 64'h1000;
        m_axis.ready = 1'b1; trigger_mode = 1'b0; capture_length = 32'd7; adc_valid = 1'b1;
        for (int w = 0; w < 12; w++) begin
            if (w == 1) chk("t1_armed", 64'(fsm_state), 64'(STATE_ARMED));
            if (w == 2) chk("t1_capture", 64'(fsm_state), 64'(STATE_CAPTURE));
            arm = (w == 0);
            adc_data = base + 64'(w);
            if (w >= 2 && w <= 9) push(base + 64'(w), w == 9);
            step();
        end
        adc_valid = 1'b0;
        wait_done("t1_done");
        chk("t1_overflow", 64'(overflow), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Trigger-edge start, length 3, trigger rises 10 cycles after arm.
        base = 64'h2000;
        trigger_mode = 1'b1; capture_length = 32'd3; adc_valid = 1'b1;
        for (int w = 0; w < 20; w++) begin
            if (w == 10) chk("t2_armed_before_edge", 64'(fsm_state), 64'(STATE_ARMED));
            if (w == 11) chk("t2_capture_after_edge", 64'(fsm_state), 64'(STATE_CAPTURE));
            arm = (w == 0);
            trigger = (w >= 10);
            adc_data = base + 64'(w);
            if (w >= 11 && w <= 14) push(base + 64'(w), w == 14);
            step();
        end
        trigger = 1'b0; adc_valid = 1'b0;
        wait_done("t2_done");
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Overflow: 16 beats into a 4-deep FIFO with the output stalled.
        base = 64'h3000;
        m_axis.ready = 1'b0; trigger_mode = 1'b0; capture_length = 32'd15; adc_valid = 1'b1;
        for (int w = 0; w < 18; w++) begin
            arm = (w == 0);
            adc_data = base + 64'(w);
            if (w >= 2 && w <= 5) push(base + 64'(w), 1'b0);
            step();
        end
        adc_valid = 1'b0;
        chk("t3_drain", 64'(fsm_state), 64'(STATE_DRAIN));
        chk("t3_overflow_set", 64'(overflow), 64'd1);
        m_axis.ready = 1'b1;
        wait_done("t3_done");
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);
`ifdef ADC_CAPTURE_OVF_COUNT_EN
        chk("t3_ovf_count", 64'(ovf_count), 64'd12);
`endif
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort after 5 beats with the output stalled, then run a clean capture.
        base = 64'h4000;
        m_axis.ready = 1'b0; capture_length = 32'd15; adc_valid = 1'b1;
        for (int w = 0; w < 7; w++) begin
            arm = (w == 0);
            adc_data = base + 64'(w);
            step();
        end
        chk("t4_ovf_before_abort", 64'(overflow), 64'd1);
        chk("t4_valid_before_abort", 64'(m_axis.valid), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0; adc_valid = 1'b0;
        chk("t4_idle", 64'(fsm_state), 64'(STATE_IDLE));
        chk("t4_valid_dropped", 64'(m_axis.valid), 64'd0);
        chk("t4_ovf_cleared", 64'(overflow), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        m_axis.ready = 1'b1;
        repeat (3) step();
        chk("t4_fifo_empty", 64'(m_axis.valid), 64'd0);
        base = 64'h5000;
        capture_length = 32'd2; adc_valid = 1'b1;
        for (int w = 0; w < 7; w++) begin
            arm = (w == 0);
            adc_data = base + 64'(w);
            if (w >= 2 && w <= 4) push(base + 64'(w), w == 4);
            step();
        end
        adc_valid = 1'b0;
        wait_done("t4_clean_done");
        chk("t4_clean_overflow", 64'(overflow), 64'd0);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Toggling ready and adc_valid, length 31. A stray arm mid-capture must be ignored.
        base = 64'h6000;
        capture_length = 32'd31;
        for (int w = 0; w < 70; w++) begin
            if (w == 21) chk("t5_arm_ignored", 64'(fsm_state), 64'(STATE_CAPTURE));
            arm = (w == 0) || (w == 20);
            adc_valid = 1'((w % 2) == 0);
            m_axis.ready = ((w % 2) == 1);
            adc_data = base + 64'(w);
            if (w >= 2 && w <= 64 && (w % 2) == 0) push(base + 64'(w), w == 64);
            step();
        end
        arm = 1'b0; adc_valid = 1'b0; m_axis.ready = 1'b1;
        wait_done("t5_done");
        repeat (2) step();
        chk("t5_busy_low", 64'(busy), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
